// File: rtl/uart_burst_tx_pkg.sv
// uart_pkg: shared types and constants for the burst UART transmitter.
//   - uart_state_t : FSM state encoding (ST_DEBOUNCE only when UART_BURST_BTN_EN is defined)
//   - PARITY_*     : parity mode encodings for the PARITY parameter
//   - CLK_DIV_27M_115200 : default bit-time divider for a 27 MHz clock at 115200 baud
//   - parityBit()  : parity of the low dataBits bits of a byte for a given mode
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
`ifdef UART_BURST_BTN_EN
    , ST_DEBOUNCE
`endif
  } uart_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  localparam int CLK_DIV_27M_115200 = 234;

  // Bits at and above dataBits are not transmitted, so they do not contribute.
  function automatic logic parityBit(input logic [7:0] b, input int dataBits, input int mode);
    logic x;
    x = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i < dataBits) x = x ^ b[i];
    end
    return (mode == PARITY_ODD) ? ~x : x;
  endfunction

endpackage

// File: rtl/uart_burst_tx_if.sv
// uart_burst_tx_if: request/status bundle between the burst source and the transmitter.
//   data     : MEM_BYTES*8 payload, byte k = data[8k+7:8k]
//   start    : burst request level
//   busy     : burst in progress
//   done     : one-cycle pulse in the last cycle of the final stop bit
//   byte_idx : index of the byte currently on the line
// Handshake: start is a request level, not a valid/ready pair. It is accepted on
// any clock edge at which the transmitter FSM is idle; that includes the edge that
// ends the done cycle, even though busy (registered) is still high during that
// cycle. A request seen while the FSM is not idle is dropped, never queued.
// Modports: master drives data/start, slave (the transmitter) drives the status.
interface uart_burst_tx_if #(
  parameter int MEM_BYTES = 4
);
  localparam int IW = $clog2(MEM_BYTES) + 1;

  logic [MEM_BYTES*8-1:0] data;
  logic                   start;
  logic                   busy;
  logic                   done;
  logic [IW-1:0]          byte_idx;

  modport master (output data, output start, input busy, input done, input byte_idx);
  modport slave  (input data, input start, output busy, output done, output byte_idx);
endinterface

// File: rtl/uart_burst_tx_baud_counter.sv
// uart_baud_counter: bit-time counter, reusable by a receiver.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : hold the count at zero
//   tick       : high in the last cycle of each CLK_DIV-cycle bit time
module uart_baud_counter #(
  parameter int CLK_DIV = 234
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          cnt <= '0;
    else if (clear)      cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                 cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/uart_burst_tx.sv
// uart_burst_tx: burst UART transmitter. On a request it snapshots the whole
// payload and sends MEM_BYTES frames back to back, byte 0 first, LSB first.
// Optional feature macro: UART_BURST_BTN_EN (adds btn_n, debounced re-arm).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : uart_burst_tx_if.slave (data, start in; busy, done, byte_idx out)
//   btn_n      : active-low push button (only with UART_BURST_BTN_EN)
//   uart_tx    : serial line, idle high
//   dbgState   : current FSM state
// All outputs are registered from the FSM state, so the line trails the state by
// one cycle: a request sampled at edge N shows on uart_tx/busy at edge N+1.
module uart_burst_tx
  import uart_pkg::*;
#(
  parameter int CLK_DIV         = CLK_DIV_27M_115200,
  parameter int MEM_BYTES       = 4,
  parameter int DATA_BITS       = 8,
  parameter int PARITY          = PARITY_NONE,
  parameter int STOP_BITS       = 1,
  parameter int DEBOUNCE_CYCLES = 270000
) (
  input  logic        clk,
  input  logic        rst_n,
  uart_burst_tx_if.slave bus,
`ifdef UART_BURST_BTN_EN
  input  logic        btn_n,
`endif
  output logic        uart_tx,
  output uart_state_t dbgState
);
  localparam int IW = $clog2(MEM_BYTES) + 1;
  localparam logic [IW-1:0] LAST_BYTE = IW'(MEM_BYTES - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  uart_state_t            state;
  logic [MEM_BYTES*8-1:0] shadow;
  logic [7:0]             shiftReg;
  logic                   parReg;
  logic [2:0]             bitIdx;
  logic                   stopIdx;
  logic [IW-1:0]          byteCnt;
  logic [IW-1:0]          byteNext;
  logic [7:0]             nextByte;
  logic                   tick;
  logic                   baudClear;
  logic                   trig;
  logic                   txNext;
  logic                   doneNext;
  logic                   busyNext;

`ifdef UART_BURST_BTN_EN
  localparam int DBW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  logic [DBW-1:0] dbCnt;
`endif

  assign dbgState = state;
  assign byteNext = byteCnt + 1'b1;

  uart_baud_counter #(.CLK_DIV(CLK_DIV)) baud (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (baudClear),
    .tick  (tick)
  );

  always_comb begin
    trig      = bus.start;
    baudClear = (state == ST_IDLE);
    busyNext  = (state != ST_IDLE);
`ifdef UART_BURST_BTN_EN
    trig      = bus.start | ~btn_n;
    baudClear = (state == ST_IDLE) || (state == ST_DEBOUNCE);
    busyNext  = (state != ST_IDLE) && (state != ST_DEBOUNCE);
`endif
    // Loop select keeps the byte pick in range for every MEM_BYTES.
    nextByte = 8'h00;
    for (int k = 0; k < MEM_BYTES; k++) begin
      if (byteNext == IW'(k)) nextByte = shadow[8*k +: 8];
    end
    case (state)
      ST_START:  txNext = 1'b0;
      ST_DATA:   txNext = shiftReg[0];
      ST_PARITY: txNext = parReg;
      default:   txNext = 1'b1;
    endcase
    doneNext = (state == ST_STOP) && tick && (stopIdx == STOP_LAST) && (byteCnt == LAST_BYTE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      shadow       <= '0;
      shiftReg     <= '0;
      parReg       <= 1'b0;
      bitIdx       <= '0;
      stopIdx      <= 1'b0;
      byteCnt      <= '0;
      uart_tx      <= 1'b1;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.byte_idx <= '0;
`ifdef UART_BURST_BTN_EN
      dbCnt        <= '0;
`endif
    end else begin
      uart_tx      <= txNext;
      bus.busy     <= busyNext;
      bus.done     <= doneNext;
      bus.byte_idx <= byteCnt;
      case (state)
        ST_IDLE: begin
          if (trig) begin
            shadow   <= bus.data;
            byteCnt  <= '0;
            shiftReg <= bus.data[7:0];
            parReg   <= parityBit(bus.data[7:0], DATA_BITS, PARITY);
            state    <= ST_START;
          end
        end
        ST_START: begin
          if (tick) begin
            bitIdx <= '0;
            state  <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (tick) begin
            shiftReg <= {1'b0, shiftReg[7:1]};
            if (bitIdx == LAST_BIT) begin
              stopIdx <= 1'b0;
              state   <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
            end else begin
              bitIdx <= bitIdx + 3'd1;
            end
          end
        end
        ST_PARITY: begin
          if (tick) begin
            stopIdx <= 1'b0;
            state   <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (stopIdx != STOP_LAST) begin
              stopIdx <= 1'b1;
            end else if (byteCnt == LAST_BYTE) begin
`ifdef UART_BURST_BTN_EN
              dbCnt <= '0;
              state <= ST_DEBOUNCE;
`else
              state <= ST_IDLE;
`endif
            end else begin
              // Next frame starts immediately: no idle gap between bytes.
              byteCnt  <= byteNext;
              shiftReg <= nextByte;
              parReg   <= parityBit(nextByte, DATA_BITS, PARITY);
              state    <= ST_START;
            end
          end
        end
`ifdef UART_BURST_BTN_EN
        ST_DEBOUNCE: begin
          // Re-arm only after DEBOUNCE_CYCLES consecutive high samples.
          if (!btn_n) begin
            dbCnt <= '0;
          end else if (dbCnt == DB_LAST) begin
            dbCnt <= '0;
            state <= ST_IDLE;
          end else begin
            dbCnt <= dbCnt + 1'b1;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_burst_tx.sv
// tb_uart_burst_tx: directed bench for uart_burst_tx with three configurations
// (A: 8N1 2 bytes, B: 7E2 2 bytes, C: 7O1 1 byte), all with a 4-cycle bit time.
module tb_uart_burst_tx;
  import uart_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // stimulus state
  logic        start = 1'b0;
  int          sel = 0;
  logic [15:0] dataA = 16'hA55A;
  logic [15:0] dataB = 16'h7F83;
  logic [7:0]  dataC = 8'h83;
  logic        btnN = 1'b1;

  uart_burst_tx_if #(.MEM_BYTES(2)) ifA ();
  uart_burst_tx_if #(.MEM_BYTES(2)) ifB ();
  uart_burst_tx_if #(.MEM_BYTES(1)) ifC ();

  assign ifA.data  = dataA;
  assign ifB.data  = dataB;
  assign ifC.data  = dataC;
  assign ifA.start = start && (sel == 0);
  assign ifB.start = start && (sel == 1);
  assign ifC.start = start && (sel == 2);

  logic txA, txB, txC;
  uart_state_t stA, stB, stC;

  uart_burst_tx #(.CLK_DIV(4), .MEM_BYTES(2), .DATA_BITS(8), .PARITY(PARITY_NONE),
                  .STOP_BITS(1), .DEBOUNCE_CYCLES(16)) dutA (
    .clk(clk), .rst_n(rst_n), .bus(ifA),
`ifdef UART_BURST_BTN_EN
    .btn_n(btnN),
`endif
    .uart_tx(txA), .dbgState(stA));

  uart_burst_tx #(.CLK_DIV(4), .MEM_BYTES(2), .DATA_BITS(7), .PARITY(PARITY_EVEN),
                  .STOP_BITS(2), .DEBOUNCE_CYCLES(16)) dutB (
    .clk(clk), .rst_n(rst_n), .bus(ifB),
`ifdef UART_BURST_BTN_EN
    .btn_n(1'b1),
`endif
    .uart_tx(txB), .dbgState(stB));

  uart_burst_tx #(.CLK_DIV(4), .MEM_BYTES(1), .DATA_BITS(7), .PARITY(PARITY_ODD),
                  .STOP_BITS(1), .DEBOUNCE_CYCLES(16)) dutC (
    .clk(clk), .rst_n(rst_n), .bus(ifC),
`ifdef UART_BURST_BTN_EN
    .btn_n(1'b1),
`endif
    .uart_tx(txC), .dbgState(stC));

  // observation mux onto the DUT under test
  logic       mTx, mBusy, mDone;
  logic [1:0] mIdx;
  always_comb begin
    mTx = txA; mBusy = ifA.busy; mDone = ifA.done; mIdx = ifA.byte_idx;
    case (sel)
      1: begin mTx = txB; mBusy = ifB.busy; mDone = ifB.done; mIdx = ifB.byte_idx; end
      2: begin mTx = txC; mBusy = ifC.busy; mDone = ifC.done; mIdx = {1'b0, ifC.byte_idx}; end
      default: ;
    endcase
  end

  int doneCntA = 0;
  always @(negedge clk) if (ifA.done) doneCntA <= doneCntA + 1;

  // scoreboard
  logic [31:0] exp_q[$];
  int errors = 0;
  int checks = 0;
  logic [255:0] recTx, recBusy, recDone;
  logic [1:0]   recIdx [256];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic at_cycle(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Raises start for one cycle; n is the edge that samples it.
  task automatic pulse_start(output int n);
    @(negedge clk);
    start = 1'b1;
    n = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Records outputs for cycles base..base+len-1; optionally pulses start at offset pulseAt.
  task automatic capture(input int base, input int len, input int pulseAt);
    recTx = '0; recBusy = '0; recDone = '0;
    for (int k = 0; k < len; k++) begin
      at_cycle(base + k);
      recTx[k] = mTx; recBusy[k] = mBusy; recDone[k] = mDone; recIdx[k] = mIdx;
      if (pulseAt >= 0) start = (k == pulseAt);
    end
    start = 1'b0;
  endtask

  // Bit i occupies offsets 1+4i..4+4i; sample mid-bit. First bit ends up as MSB.
  function automatic logic [31:0] serial_bits(input int nbits);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < nbits; i++) r = {r[30:0], recTx[3 + 4*i]};
    return r;
  endfunction

  int n;
  int r;
  int d0;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_tx", txA, 1'b1);
    check("rst_busy", ifA.busy, 1'b0);
    check("rst_done", ifA.done, 1'b0);
    check("rst_idx", ifA.byte_idx, 2'd0);
    check("rst_state_a", 32'(stA), 32'(ST_IDLE));
    check("rst_state_bc", {16'(stB), 16'(stC)}, {16'(ST_IDLE), 16'(ST_IDLE)});
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // A: 8N1, A55A -> 5A then A5
    sel = 0;
    exp_q.push_back(32'(20'b0_01011010_1_0_10100101_1));
    pulse_start(n);
    capture(n, 100, -1);
    check("a_idle_at_trigger", recTx[0], 1'b1);
    check("a_busy_at_trigger", recBusy[0], 1'b0);
    check("a_bits", serial_bits(20), exp_q.pop_front());
    check("a_busy_rise", recBusy[1], 1'b1);
    check("a_busy_last", recBusy[80], 1'b1);
    check("a_busy_fall", recBusy[81], 1'b0);
    check("a_done_at80", recDone[80], 1'b1);
    check("a_done_once", $countones(recDone), 1);
    check("a_idx_frame0", recIdx[40], 2'd0);
    check("a_idx_frame1", recIdx[41], 2'd1);
    check("a_line_idle_after", recTx[99:81], 19'h7FFFF);

    // A: payload changed right after the trigger must not leak in
    exp_q.push_back(32'(20'b0_01011010_1_0_10100101_1));
    pulse_start(n);
    dataA = 16'hFFFF;
    capture(n, 90, -1);
    dataA = 16'hA55A;
    check("a_snapshot_bits", serial_bits(20), exp_q.pop_front());
    check("a_snapshot_done", recDone[80], 1'b1);

    // B: 7E2, bytes 83 (parity 0) and 7F (parity 1), start pulsed mid-burst
    sel = 1;
    exp_q.push_back(32'(22'b0_1100000_0_11_0_1111111_1_11));
    pulse_start(n);
    capture(n, 128, 20);
    check("b_bits", serial_bits(22), exp_q.pop_front());
    check("b_stop_gap", recTx[45:36], 10'b0111111110);
    check("b_busy_mid", recBusy[22:21], 2'b11);
    check("b_done_at88", recDone[88], 1'b1);
    check("b_done_once", $countones(recDone), 1);
    check("b_busy_fall", recBusy[89], 1'b0);
    check("b_no_extra_frame", recTx[127:89], {39{1'b1}});
    check("b_idle_after", recBusy[127:89], 39'd0);

    // C: 7O1, byte 83, bit 7 ignored, odd parity 1
    sel = 2;
    exp_q.push_back(32'(10'b0_1100000_1_1));
    pulse_start(n);
    capture(n, 48, -1);
    check("c_bits", serial_bits(10), exp_q.pop_front());
    check("c_done_at40", recDone[40], 1'b1);
    check("c_busy_fall", recBusy[41:40], 2'b01);

    // A: reset during data bit 3 of byte 1
    sel = 0;
    pulse_start(n);
    at_cycle(n + 58);
    check("pre_rst_tx", txA, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_tx", txA, 1'b1);
    check("async_rst_busy", ifA.busy, 1'b0);
    check("async_rst_idx", ifA.byte_idx, 2'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    capture(cyc, 40, -1);
    check("post_rst_line", recTx[39:0], 40'hFF_FFFF_FFFF);
    check("post_rst_busy", recBusy[39:0], 40'd0);

`ifdef UART_BURST_BTN_EN
    // button: held low -> one burst, glitchy release, second press
    d0 = doneCntA;
    btnN = 1'b0;
    repeat (200) @(negedge clk);
    check("btn_one_burst", doneCntA - d0, 1);
    check("btn_in_debounce", 32'(stA), 32'(ST_DEBOUNCE));
    btnN = 1'b1;
    r = cyc;
    at_cycle(r + 10);
    btnN = 1'b0;
    at_cycle(r + 11);
    btnN = 1'b1;
    at_cycle(r + 26);
    check("btn_glitch_restart", 32'(stA), 32'(ST_DEBOUNCE));
    at_cycle(r + 27);
    check("btn_rearmed", 32'(stA), 32'(ST_IDLE));
    btnN = 1'b0;
    repeat (3) @(negedge clk);
    btnN = 1'b1;
    repeat (120) @(negedge clk);
    check("btn_second_burst", doneCntA - d0, 2);
    check("btn_idle_end", 32'(stA), 32'(ST_IDLE));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_burst_tx.md
# uart_burst_tx

Parametrised burst UART transmitter: snapshots a multi-byte buffer on a start request and shifts it out serially, byte 0 first, with configurable frame format (data bits, parity, stop bits) and baud divider. It replaces the fixed 8N1, button-only sender. The start request comes from a synchronous handshake, or optionally from a debounced active-low push button. It sits between console/flash logic and the board `uart_tx` pin.

## Interface
- `CLK_DIV`, 234: clock cycles per bit (27 MHz / 115200); legal range ≥ 2.
- `MEM_BYTES`, 4: bytes per burst; legal range 1..256.
- `DATA_BITS`, 8: data bits per frame; legal range 5..8.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.
- `DEBOUNCE_CYCLES`, 270000: button release hold time (~10 ms); used only with the macro.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `data`  in  MEM_BYTES*8  burst payload; byte k = `data[8k+7:8k]`.
- `start`  in  1  burst request, sampled only in IDLE.
- `uart_tx`  out  1  serial line, idle high.
- `busy`  out  1  burst in progress.
- `done`  out  1  single-cycle pulse at burst end.
- `byte_idx`  out  $clog2(MEM_BYTES)+1  index of byte currently on the line.
- `btn_n`  in  1  active-low button; present only with `UART_BURST_BTN_EN`.

## Operation
- States: IDLE, START, DATA, PARITY, STOP, DEBOUNCE (DEBOUNCE exists only with the macro).
- IDLE:
  - Trigger = `start` (OR'd with `btn_n==0` with the macro).
  - On trigger: latch all of `data` into a shadow register, clear `byte_idx`, go to START.
  - `data` changes after the trigger do not affect the burst.
- START: drive 0 for one bit time.
- DATA: drive `DATA_BITS` bits, LSB first. Byte bits at and above `DATA_BITS` are ignored.
- PARITY: entered only if `PARITY != 0`.
  - Odd: XOR of the data bits, inverted.
  - Even: XOR of the data bits.
- STOP: drive 1 for `STOP_BITS` bit times.
  - If `byte_idx == MEM_BYTES-1`: burst complete.
  - Otherwise: increment `byte_idx` and go to START. There is no idle gap between frames.
- Burst complete:
  - Without macro: pulse `done`, return to IDLE.
  - With macro: pulse `done`, go to DEBOUNCE.
- DEBOUNCE: return to IDLE only after `btn_n` has been continuously high for `DEBOUNCE_CYCLES`. Any low sample restarts the count.
- `start` asserted while busy is ignored; it is not queued.
- `start` still high on the cycle after `done` (IDLE) launches a new burst, so a held level retransmits back-to-back.
- Bit counter is $clog2(CLK_DIV) bits wide and wraps at CLK_DIV-1. Each bit lasts exactly CLK_DIV cycles.

## Timing
- Reset values: `uart_tx`=1, `busy`=0, `done`=0, `byte_idx`=0, state IDLE.
- Reset asserted mid-burst forces these values immediately and asynchronously. No partial frame resumes after release.
- Trigger sampled at edge N → `uart_tx` falls and `busy` rises at edge N+1. All outputs are registered.
- Frame length F = CLK_DIV × (1 + DATA_BITS + (PARITY?1:0) + STOP_BITS) cycles.
- Burst length = MEM_BYTES × F cycles.
- `done` is high for exactly the last cycle of the final stop bit.
- `busy` falls on the edge after that cycle, together with the return to IDLE/DEBOUNCE.
- `byte_idx` changes on the same edge the next start bit begins.

## Configuration
- `UART_BURST_BTN_EN` defined:
  - `btn_n` port, DEBOUNCE state and release counter are compiled in.
  - Button press triggers a burst exactly like `start`.
  - Exactly one burst per press; re-arm requires a debounced release.
- Not defined:
  - No `btn_n` port, no DEBOUNCE state.
  - `done` returns the FSM directly to IDLE.

## Structure
- Package `uart_pkg` holds:
  - FSM state enum;
  - parity encodings `PARITY_NONE`/`PARITY_ODD`/`PARITY_EVEN`;
  - default 27 MHz/115200 divider constant.
- Sub-module `uart_baud_counter`: bit-time counter with `clear` input and `tick` output. It is reusable by a future receiver.
- FSM, shadow buffer and shift register stay in `uart_burst_tx`.

## Test plan
- CLK_DIV=4, MEM_BYTES=2, 8N1, data=16'hA55A, one-cycle `start` → line reads 0,0101 1010,1 then 0,1010 0101,1; 80 cycles; `done` once at cycle 80; `busy` falls at cycle 81.
- PARITY=2, DATA_BITS=7, byte 8'h83 → data bits 1100000, parity bit 0, stop 1; bit 7 ignored. PARITY=1 → parity bit 1.
- STOP_BITS=2 → line high for 8 cycles between frames; `start` pulsed mid-burst → no extra frame, `busy` unchanged.
- `data` changed to 16'hFFFF one cycle after start → transmitted bytes remain 5A, A5.
- `rst_n` low during bit 3 of byte 1 → `uart_tx`=1 and `busy`=0 before next edge; after release, line stays idle until a new `start`.
- With `UART_BURST_BTN_EN`, DEBOUNCE_CYCLES=16: `btn_n` held low 200 cycles → one burst only. Release with a 1-cycle glitch at release cycle 10 → restart count, IDLE at 16 clean cycles. Second press → second burst.
